// File: rtl/picorv32_trace_capture.sv
// rtl/picorv32_trace_capture.sv - PicoRV32 trace FIFO sink with Wishbone register readout (optional: TRACE_CAPTURE_IRQ_EN)
module picorv32_trace_capture #(
    parameter int DEPTH_LOG2    = 9,
    parameter int IRQ_THRESHOLD = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        trace_valid_i,
    input  logic [35:0] trace_data_i,
    input  logic        trap_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [35:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  frozen;
    logic                  enable;
    logic                  stop_on_trap;
    logic                  clear_pending;
    logic [15:0]           drop_cnt;
    logic [3:0]            hi_shadow;
    logic [3:0]            rd_hi;
    logic                  rd_pop;
    logic                  ack;
    logic [31:0]           dat;
    logic                  irq_en_rd;
    logic [15:0]           thresh_rd;

    logic        empty;
    logic        full;
    logic [2:0]  reg_sel;
    logic        bus_req;
    logic        commit;
    logic        wr_commit;
    logic        rd_commit;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        drop;
    logic [35:0] head_word;
    logic [31:0] rdata;
    logic        unused_bits;

    assign empty     = (level == '0);
    assign full      = (level == DEPTH_CNT);
    assign reg_sel   = wb_adr_i[4:2];
    assign bus_req   = wb_cyc_i & wb_stb_i & ~ack;
    assign commit    = wb_cyc_i & wb_stb_i & ack;
    assign wr_commit = commit & wb_we_i;
    assign rd_commit = commit & ~wb_we_i;
    // rd_pop was latched at accept time, so an empty FIFO at the request never pops
    assign pop       = rd_commit & (reg_sel == 3'd2) & rd_pop & ~clear_pending;
    assign push_req  = trace_valid_i & enable & ~frozen & ~clear_pending;
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign head_word = (empty | clear_pending) ? 36'd0 : mem[head];
    assign wb_ack_o  = ack;
    assign wb_dat_o  = dat;
    assign unused_bits = ^{wb_dat_i, wb_adr_i[1:0]};

    // register read mux, evaluated on the request cycle and captured with the ack
    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            3'd0:    rdata = {12'd0, frozen, overflow, full, empty, 16'(level)};
            3'd1:    rdata = {28'd0, irq_en_rd, stop_on_trap, 1'b0, enable};
            3'd2:    rdata = head_word[31:0];
            3'd3:    rdata = {28'd0, hi_shadow};
            3'd4:    rdata = {16'd0, drop_cnt};
            3'd5:    rdata = {16'd0, thresh_rd};
            default: rdata = 32'd0;
        endcase
    end

    // FIFO storage; no reset needed since level gates every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[tail] <= trace_data_i;
        end
    end

    // Wishbone handshake: one-cycle ack, read data and pop intent latched at accept
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack    <= 1'b0;
            dat    <= 32'd0;
            rd_hi  <= 4'd0;
            rd_pop <= 1'b0;
        end else begin
            ack <= bus_req;
            if (bus_req) begin
                dat    <= rdata;
                rd_hi  <= head_word[35:32];
                rd_pop <= ~wb_we_i & (reg_sel == 3'd2) & ~empty & ~clear_pending;
            end
        end
    end

    // FIFO pointers, status flags and control register; clear wins over everything
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head          <= '0;
            tail          <= '0;
            level         <= '0;
            overflow      <= 1'b0;
            frozen        <= 1'b0;
            drop_cnt      <= 16'd0;
            hi_shadow     <= 4'd0;
            enable        <= 1'b0;
            stop_on_trap  <= 1'b1;
            clear_pending <= 1'b0;
        end else begin
            clear_pending <= wr_commit & (reg_sel == 3'd1) & wb_dat_i[1];
            if (wr_commit && reg_sel == 3'd1) begin
                enable       <= wb_dat_i[0];
                stop_on_trap <= wb_dat_i[2];
            end
            if (clear_pending) begin
                head      <= '0;
                tail      <= '0;
                level     <= '0;
                overflow  <= 1'b0;
                frozen    <= 1'b0;
                drop_cnt  <= 16'd0;
                hi_shadow <= 4'd0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (push && !pop) begin
                    level <= level + 1'b1;
                end else if (pop && !push) begin
                    level <= level - 1'b1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end
                if (enable && stop_on_trap && trap_i) begin
                    frozen <= 1'b1;
                end
                if (rd_commit && reg_sel == 3'd2) begin
                    hi_shadow <= rd_hi;
                end
            end
        end
    end

`ifdef TRACE_CAPTURE_IRQ_EN
    logic        irq_en;
    logic [15:0] thresh;
    logic        irq;

    // interrupt enable, threshold and registered fill-level interrupt
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_en <= 1'b0;
            thresh <= 16'(IRQ_THRESHOLD);
            irq    <= 1'b0;
        end else begin
            if (wr_commit && reg_sel == 3'd1) begin
                irq_en <= wb_dat_i[3];
            end
            if (wr_commit && reg_sel == 3'd5) begin
                thresh <= wb_dat_i[15:0];
            end
            irq <= irq_en & ((16'(level) >= thresh) | overflow);
        end
    end

    assign irq_o     = irq;
    assign irq_en_rd = irq_en;
    assign thresh_rd = thresh;
`else
    assign irq_o     = 1'b0;
    assign irq_en_rd = 1'b0;
    assign thresh_rd = 16'd0;
`endif

endmodule

// File: tb/tb_picorv32_trace_capture.sv
// tb/tb_picorv32_trace_capture.sv - directed self-checking bench for picorv32_trace_capture
module tb_picorv32_trace_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_valid;
    logic [35:0] trace_data;
    logic        trap;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    picorv32_trace_capture #(.DEPTH_LOG2(2), .IRQ_THRESHOLD(256)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .trace_valid_i (trace_valid),
        .trace_data_i  (trace_data),
        .trap_i        (trap),
        .wb_cyc_i      (cyc),
        .wb_stb_i      (stb),
        .wb_we_i       (we),
        .wb_adr_i      (adr),
        .wb_dat_i      (dat_w),
        .wb_dat_o      (dat_r),
        .wb_ack_o      (ack),
        .irq_o         (irq)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                           output logic [31:0] r);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 16);
        if (!ack) begin
            check_eq("ack_timeout", 64'd0, 64'd1);
            r = 32'd0;
        end else begin
            r = dat_r;
            @(posedge clk); #1;
            check_eq("ack_single_cycle", 64'(ack), 64'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, r);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, a, 32'd0, r);
        check_eq(tag, 64'(r), 64'(exp));
    endtask

    task automatic push_words(input logic [35:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            trace_valid = 1'b1;
            trace_data  = base + 36'(i);
        end
        @(negedge clk);
        trace_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int n;
        rst_n = 1'b0; trace_valid = 1'b0; trace_data = '0; trap = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", 64'(ack), 64'd0);
        check_eq("rst_dat", 64'(dat_r), 64'd0);
        check_eq("rst_irq", 64'(irq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        rd_check("rst_status", 5'h00, 32'h0001_0000);
        rd_check("rst_ctrl",   5'h04, 32'h0000_0004);
        rd_check("rst_drop",   5'h10, 32'd0);
        rd_check("rst_hi",     5'h0C, 32'd0);

        // basic capture and readout
        wb_write(5'h04, 32'h1);
        push_words(36'h1_0000_0001, 1);
        push_words(36'h2_0000_0002, 1);
        push_words(36'hF_FFFF_FFFF, 1);
        rd_check("basic_status", 5'h00, 32'h0000_0003);
        rd_check("basic_lo0", 5'h08, 32'h0000_0001);
        rd_check("basic_hi0", 5'h0C, 32'h1);
        rd_check("basic_lo1", 5'h08, 32'h0000_0002);
        rd_check("basic_hi1", 5'h0C, 32'h2);
        rd_check("basic_lo2", 5'h08, 32'hFFFF_FFFF);
        rd_check("basic_hi2", 5'h0C, 32'hF);
        rd_check("basic_empty", 5'h00, 32'h0001_0000);

        // overflow: 6 words into a 4-entry FIFO
        push_words(36'h5_0000_0100, 6);
        rd_check("ovf_status", 5'h00, 32'h0006_0004);
        rd_check("ovf_drop",   5'h10, 32'd2);
        for (int i = 0; i < 4; i++) begin
            rd_check($sformatf("ovf_lo%0d", i), 5'h08, 32'h100 + 32'(i));
        end
        rd_check("ovf_after", 5'h00, 32'h0005_0000);

        // clear with enable and stop_on_trap kept on
        wb_write(5'h04, 32'h7);
        @(posedge clk);
        rd_check("clr_status", 5'h00, 32'h0001_0000);
        rd_check("clr_drop",   5'h10, 32'd0);

        // trap: word alongside trap is kept, later words ignored
        @(negedge clk);
        trace_valid = 1'b1; trace_data = 36'h7_AAAA_0001; trap = 1'b1;
        @(negedge clk);
        trace_data = 36'h7_AAAA_0002; trap = 1'b0;
        @(negedge clk);
        trace_valid = 1'b0;
        push_words(36'h7_AAAA_0003, 2);
        rd_check("trap_status", 5'h00, 32'h0008_0001);
        rd_check("trap_drop",   5'h10, 32'd0);
        wb_write(5'h04, 32'h3);
        @(posedge clk);
        rd_check("unfreeze_status", 5'h00, 32'h0001_0000);
        rd_check("unfreeze_ctrl",   5'h04, 32'h0000_0001);
        push_words(36'h6_BBBB_0001, 1);
        rd_check("resume_status", 5'h00, 32'h0000_0001);
        rd_check("resume_lo", 5'h08, 32'hBBBB_0001);

        // full FIFO: pop and push on the same edge
        push_words(36'h3_CAFE_0000, 4);
        rd_check("full_status", 5'h00, 32'h0002_0004);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h08;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 16);
        check_eq("simul_ack", 64'(ack), 64'd1);
        trace_valid = 1'b1; trace_data = 36'h9_1234_5678;
        r = dat_r;
        @(posedge clk); #1;
        trace_valid = 1'b0; cyc = 1'b0; stb = 1'b0;
        check_eq("simul_lo", 64'(r), 64'h0000_0000_CAFE_0000);
        rd_check("simul_status", 5'h00, 32'h0002_0004);
        rd_check("simul_drop",   5'h10, 32'd0);
        for (int i = 1; i < 4; i++) begin
            rd_check($sformatf("simul_lo%0d", i), 5'h08, 32'hCAFE_0000 + 32'(i));
        end
        rd_check("simul_tail_lo", 5'h08, 32'h1234_5678);
        rd_check("simul_tail_hi", 5'h0C, 32'h9);

        // empty reads and unmapped address
        rd_check("empty_lo", 5'h08, 32'd0);
        rd_check("empty_hi", 5'h0C, 32'd0);
        rd_check("empty_status", 5'h00, 32'h0001_0000);
        rd_check("unmapped", 5'h1C, 32'd0);

`ifdef TRACE_CAPTURE_IRQ_EN
        wb_write(5'h14, 32'd2);
        rd_check("thresh", 5'h14, 32'd2);
        wb_write(5'h04, 32'h9);
        rd_check("irq_ctrl", 5'h04, 32'h9);
        @(negedge clk);
        trace_valid = 1'b1; trace_data = 36'h1_0000_0011;
        @(negedge clk);
        trace_data = 36'h1_0000_0012;
        @(negedge clk);
        trace_valid = 1'b0;
        check_eq("irq_before", 64'(irq), 64'd0);
        @(posedge clk); #1;
        check_eq("irq_set", 64'(irq), 64'd1);
        rd_check("irq_pop", 5'h08, 32'h0000_0011);
        check_eq("irq_hold", 64'(irq), 64'd1);
        @(posedge clk); #1;
        check_eq("irq_clear", 64'(irq), 64'd0);
`else
        wb_write(5'h14, 32'd5);
        rd_check("thresh_off", 5'h14, 32'd0);
        wb_write(5'h04, 32'h9);
        rd_check("irq_ctrl_off", 5'h04, 32'h1);
        push_words(36'h1_0000_0011, 2);
        @(posedge clk); #1;
        check_eq("irq_off", 64'(irq), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/picorv32_trace_capture.md
Name: picorv32_trace_capture

Overview:
- Hardware sink for the PicoRV32 36-bit instruction trace stream (trace_valid/trace_data); the receiving end of the core's trace port.
- Buffers trace words in an on-chip FIFO and exposes them to a Wishbone master (debug bridge or the CPU itself) through a small register file.
- Freezes capture on trap so the last executed instructions survive for post-mortem readout.
- Sits beside the core in the demo system, on the same clock.

Parameters:
- DEPTH_LOG2, 9, FIFO depth is 2**DEPTH_LOG2 entries (legal range 2..15).
- IRQ_THRESHOLD, 256, reset value of THRESH register; used only with the optional feature.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- trace_valid_i  in  1  trace word strobe, one word per cycle when high.
- trace_data_i  in  36  trace word.
- trap_i  in  1  core trap indication, level.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  5  byte address; bits [4:2] decoded.
- wb_dat_i  in  32  write data; byte selects ignored.
- wb_dat_o  out  32  read data, valid with wb_ack_o.
- wb_ack_o  out  1  single-cycle acknowledge.
- irq_o  out  1  fill-level interrupt; constant 0 without the optional feature.

Behaviour:
- Reset (async assert, sync deassert by the system): FIFO empty, level 0, overflow 0, frozen 0, DROP 0, CTRL.enable 0, CTRL.stop_on_trap 1, wb_ack_o 0, wb_dat_o 0, irq_o 0, HI shadow 0.
- Register map (wb_adr_i[4:2]):
  - 0 STATUS (RO): [15:0] level, [16] empty, [17] full, [18] overflow, [19] frozen.
  - 1 CTRL (RW): [0] enable, [1] clear (write 1; self-clearing; reads 0), [2] stop_on_trap, [3] irq_en.
  - 2 DATA_LO (RO, pops): bits [31:0] of the head word.
  - 3 DATA_HI (RO): [3:0] HI shadow.
  - 4 DROP (RO): [15:0] saturating dropped-word count.
  - 5 THRESH (RW): [15:0].
  - Unmapped addresses: read 0, writes ignored, still acked.
- Wishbone handshake: classic single-cycle. wb_ack_o rises the cycle after cyc&stb is first sampled high without ack and stays high for exactly 1 cycle, so back-to-back accesses take 2 cycles each. Register writes and pops commit on the ack cycle.
- Capture: push on the rising edge where trace_valid_i & enable & !frozen & !clear-pending. Level and STATUS reflect the push from the next cycle.
- Full: a push while full with no simultaneous pop drops the word, sets overflow (sticky) and increments DROP (saturating at 0xFFFF). Push and pop in the same cycle while full: push accepted, level unchanged.
- Pop: a DATA_LO read while non-empty returns the head word [31:0], loads HI shadow with [35:32], and advances the head on the ack cycle. A DATA_LO read while empty returns 0, loads HI shadow with 0, and leaves the FIFO unchanged. Pointers wrap modulo 2**DEPTH_LOG2.
- Freeze: when enable & stop_on_trap & trap_i is sampled high, frozen sets the next cycle. A trace word in the same cycle as trap_i is still captured. Frozen blocks pushes only; reads continue.
- Clear: a CTRL write with bit1=1 empties the FIFO and zeroes overflow, frozen, DROP and HI shadow on the cycle after ack. The enable, stop_on_trap and irq_en bits from the same write take effect normally.
- Reset mid-transfer: ack drops immediately; no partial state survives.

Optional Feature:
- Macro TRACE_CAPTURE_IRQ_EN.
- Defined: THRESH register implemented, reset value IRQ_THRESHOLD. irq_o is registered and asserts when CTRL.irq_en & (level >= THRESH), or when CTRL.irq_en & overflow; it deasserts the cycle after the condition clears.
- Undefined: THRESH reads 0 and ignores writes; CTRL[3] reads 0; irq_o tied 0.

Test Plan:
- Reset, then write CTRL=0x1 and inject 3 words 0x1_0000_0001, 0x2_0000_0002, 0xF_FFFF_FFFF -> STATUS level=3, empty=0; DATA_LO/DATA_HI reads return 0x00000001/0x1, 0x00000002/0x2, 0xFFFFFFFF/0xF; a final STATUS read shows empty=1.
- DEPTH_LOG2=2, inject 6 consecutive words -> level=4, full=1, overflow=1, DROP=2; reads return the first 4 words in order.
- Assert trap_i together with a valid word while stop_on_trap=1 -> that word is stored, frozen=1, later words ignored; CTRL write 0x3 -> level=0, frozen=0, DROP=0, capture resumes.
- Hold the FIFO full and issue a DATA_LO read while trace_valid_i is high on the ack cycle -> level stays 4, DROP unchanged, the new word appears at the tail.
- DATA_LO read while empty -> returns 0, DATA_HI returns 0, level stays 0; read address 0x1C -> returns 0 with a single-cycle ack.
- With TRACE_CAPTURE_IRQ_EN: THRESH=2, CTRL=0x9 (enable, irq_en), push 2 words -> irq_o high the cycle after level reaches 2; one pop -> irq_o low the next cycle.
